ahb_icache_nway: RTL and testbench

AHB_ICACHE_NWAY -- requirements
Module: ahb_icache_nway

---
 rtl/ahb_icache_nway_if.sv | 26 ++
 rtl/ahb_icache_nway.sv | 106 ++++++++++
 tb/tb_ahb_icache_nway.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ahb_icache_nway_if.sv
// ahb_icache_nway_if: upstream AHB-lite read port, downstream burst master port and flush strobe
interface ahb_icache_nway_if;
  logic [31:0] s_haddr;
  logic [1:0] s_htrans;
  logic s_hwrite;
  logic s_hreadyout;
  logic [31:0] s_hrdata;
  logic s_hresp;
  logic [31:0] m_haddr;
  logic [1:0] m_htrans;
  logic [2:0] m_hburst;
  logic [2:0] m_hsize;
  logic m_hwrite;
  logic m_hready;
  logic [31:0] m_hrdata;
  logic m_hresp;
  logic inv;
  modport slave (
    input s_haddr, s_htrans, s_hwrite, m_hready, m_hrdata, m_hresp, inv,
    output s_hreadyout, s_hrdata, s_hresp, m_haddr, m_htrans, m_hburst, m_hsize, m_hwrite
  );
  modport master (
    output s_haddr, s_htrans, s_hwrite, m_hready, m_hrdata, m_hresp, inv,
    input s_hreadyout, s_hrdata, s_hresp, m_haddr, m_htrans, m_hburst, m_hsize, m_hwrite
  );
endinterface

// File: rtl/ahb_icache_nway.sv
// ahb_icache_nway: set-associative read-only AHB instruction cache with critical-word-first WRAP refill
module ahb_icache_nway #(
  parameter int CACHE_SIZE = 8192,
  parameter int WAYS = 2,
  parameter int LINE_WORDS = 4
) (
  input logic hclk,
  input logic hrst,
  ahb_icache_nway_if.slave bus
);
  localparam int SETS = CACHE_SIZE / (WAYS * LINE_WORDS * 4);
  localparam int OFF_W = $clog2(LINE_WORDS * 4);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 32 - IDX_W - OFF_W;
  localparam int WW = OFF_W - 2;
  localparam int RW = WAYS > 1 ? $clog2(WAYS) : 1;
  typedef enum logic [2:0] {IDLE, LOOKUP, REFILL, INSTALL, ERR1, ERR2, FLUSH} state_t;
  state_t state, state_n;
  logic [31:2] addr;
  logic [31:0] data [WAYS][SETS][LINE_WORDS];
  logic [TAG_W-1:0] tags [WAYS][SETS];
  logic [SETS-1:0] valid [WAYS];
  logic [RW-1:0] rr [SETS];
  logic [31:0] fill [LINE_WORDS];
  logic [WW:0] acnt, dcnt;
  logic pend, hit, accept, done, fl, dph, last;
  logic [RW-1:0] hway, vic;
  logic [TAG_W-1:0] tag;
  logic [IDX_W-1:0] idx;
  logic [WW-1:0] wrd, aw, dw;
  assign tag = addr[31 -: TAG_W];
  assign idx = addr[OFF_W +: IDX_W];
  assign wrd = addr[2 +: WW];
  assign aw = wrd + acnt[WW-1:0];
  assign dw = wrd + dcnt[WW-1:0];
  assign dph = acnt != dcnt;
  assign last = dph && bus.m_hready && dcnt == (WW+1)'(LINE_WORDS - 1);
  assign accept = bus.s_htrans[1] && !bus.s_hwrite && bus.s_hreadyout;
  assign done = bus.s_hreadyout;
  assign fl = done && (bus.inv || pend);
  assign bus.m_hburst = LINE_WORDS == 8 ? 3'b100 : 3'b010;
  assign bus.m_hsize = 3'b010;
  assign bus.m_hwrite = 1'b0;
  // victim: lowest invalid way wins over the round-robin pointer
  always_comb begin
    hit = 1'b0;
    hway = '0;
    for (int w = 0; w < WAYS; w++)
      if (valid[w][idx] && tags[w][idx] == tag) begin
        hit = 1'b1;
        hway = RW'(w);
      end
    vic = rr[idx];
    for (int w = WAYS - 1; w >= 0; w--)
      if (!valid[w][idx]) vic = RW'(w);
  end
  always_comb begin
    bus.s_hreadyout = !(state == REFILL || state == ERR1 || (state == LOOKUP && !hit));
    bus.s_hresp = state == ERR1 || state == ERR2;
    bus.s_hrdata = state == LOOKUP && hit ? data[hway][idx][wrd] : state == INSTALL ? fill[wrd] : '0;
    bus.m_htrans = state == REFILL && !acnt[WW] ? (acnt == '0 ? 2'b10 : 2'b11) : 2'b00;
    bus.m_haddr = state == REFILL ? {tag, idx, aw, 2'b00} : '0;
  end
  always_comb begin
    state_n = state;
    if (done) state_n = accept ? LOOKUP : fl ? FLUSH : IDLE;
    else if (state == LOOKUP) state_n = REFILL;
    else if (state == REFILL) state_n = bus.m_hresp && dph ? ERR1 : last ? INSTALL : REFILL;
    else if (state == ERR1) state_n = ERR2;
  end
  always_ff @(posedge hclk) begin
    if (hrst) begin
      state <= IDLE;
      pend <= 1'b0;
      addr <= '0;
      acnt <= '0;
      dcnt <= '0;
      for (int w = 0; w < WAYS; w++) valid[w] <= '0;
      for (int s = 0; s < SETS; s++) rr[s] <= '0;
    end else begin
      state <= state_n;
      pend <= (pend | bus.inv) & ~done;
      if (accept) addr <= bus.s_haddr[31:2];
      if (state != REFILL) begin
        acnt <= '0;
        dcnt <= '0;
      end else begin
        if (bus.m_hready && !acnt[WW]) acnt <= acnt + 1'b1;
        if (dph && bus.m_hready) dcnt <= dcnt + 1'b1;
      end
      if (state == INSTALL) begin
        valid[vic][idx] <= 1'b1;
        rr[idx] <= rr[idx] == RW'(WAYS - 1) ? '0 : rr[idx] + 1'b1;
      end
      // a flush in the completing cycle also drops the line installed by it
      if (fl) for (int w = 0; w < WAYS; w++) valid[w] <= '0;
    end
  end
  always_ff @(posedge hclk) begin
    if (state == REFILL && dph && bus.m_hready) fill[dw] <= bus.m_hrdata;
    if (state == INSTALL) begin
      tags[vic][idx] <= tag;
      for (int k = 0; k < LINE_WORDS; k++) data[vic][idx][k] <= fill[k];
    end
  end
endmodule

// File: tb/tb_ahb_icache_nway.sv
// tb_ahb_icache_nway: directed checks of hit/miss timing, refill order, eviction, errors, flush and reset
module tb_ahb_icache_nway;
  logic hclk, hrst;
  ahb_icache_nway_if bus ();
  ahb_icache_nway dut (.hclk(hclk), .hrst(hrst), .bus(bus));
  initial hclk = 1'b0;
  always #5 hclk = ~hclk;
  int n_run = 0, n_fail = 0, nact = 0;
  logic [31:0] aq [$];
  logic [1:0] tq [$];
  logic dact, e2, earm, ehit;
  logic [31:0] daddr;
  int dbeat;
  // zero-wait memory; word = address ^ 0xDEAD0000; optional two-cycle ERROR on beat 2
  assign ehit = earm && dact && dbeat == 2;
  assign bus.m_hready = !ehit || e2;
  assign bus.m_hresp = ehit;
  assign bus.m_hrdata = dact ? daddr ^ 32'hDEAD0000 : 32'h0;
  always_ff @(posedge hclk) begin
    if (hrst) begin
      dact <= 1'b0;
      e2 <= 1'b0;
      dbeat <= 0;
      daddr <= '0;
    end else begin
      e2 <= ehit && !e2;
      if (bus.m_hready) begin
        dact <= bus.m_htrans[1];
        daddr <= bus.m_haddr;
        if (bus.m_htrans[1]) dbeat <= bus.m_htrans == 2'b10 ? 0 : dbeat + 1;
      end
    end
  end
  initial forever begin
    @(negedge hclk);
    if (bus.m_htrans != 2'b00) nact++;
    if (bus.m_htrans[1] && bus.m_hready) begin
      aq.push_back(bus.m_haddr);
      tq.push_back(bus.m_htrans);
    end
  end
  task automatic chk(input string t, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", t, got, exp);
    end
  endtask
  task automatic rd(input logic [31:0] a, input logic w, input int ivk, output logic [31:0] d,
                    output int ws, output logic r, output logic rw);
    bus.s_haddr = a;
    bus.s_htrans = 2'b10;
    bus.s_hwrite = w;
    bus.inv = ivk == 0;
    @(posedge hclk); #1;
    bus.s_htrans = 2'b00;
    bus.s_hwrite = 1'b0;
    bus.inv = 1'b0;
    ws = 0;
    rw = 1'b0;
    while (!bus.s_hreadyout && ws < 40) begin
      rw = bus.s_hresp;
      bus.inv = ivk == ws + 1;
      @(posedge hclk); #1;
      ws++;
    end
    bus.inv = 1'b0;
    d = bus.s_hrdata;
    r = bus.s_hresp;
  endtask
  task automatic rdc(input string t, input logic [31:0] a, input int ivk, input logic [31:0] ed, input int ews);
    logic [31:0] d;
    int ws;
    logic r, rw;
    rd(a, 1'b0, ivk, d, ws, r, rw);
    chk({t, "_data"}, d, ed);
    chk({t, "_waits"}, ws, ews);
    chk({t, "_resp"}, r, 0);
  endtask
  task automatic idle_cycle();
    @(posedge hclk); #1;
  endtask
  initial begin
    logic [31:0] d;
    int ws, n0;
    logic r, rw;
    earm = 1'b0;
    hrst = 1'b1;
    bus.s_haddr = '0;
    bus.s_htrans = 2'b00;
    bus.s_hwrite = 1'b0;
    bus.inv = 1'b0;
    repeat (3) @(posedge hclk);
    #1;
    chk("rst_hreadyout", bus.s_hreadyout, 1);
    chk("rst_hresp", bus.s_hresp, 0);
    chk("rst_hrdata", bus.s_hrdata, 0);
    chk("rst_mhtrans", bus.m_htrans, 0);
    chk("rst_mhaddr", bus.m_haddr, 0);
    chk("hburst", bus.m_hburst, 3'b010);
    chk("hsize", bus.m_hsize, 3'b010);
    chk("hwrite", bus.m_hwrite, 0);
    hrst = 1'b0;
    aq.delete();
    tq.delete();
    rdc("miss1008", 32'h1008, -1, 32'hDEAD1008, 6);
    chk("beats", aq.size(), 4);
    if (aq.size() == 4) begin
      chk("beat0", aq[0], 32'h1008);
      chk("beat1", aq[1], 32'h100C);
      chk("beat2", aq[2], 32'h1000);
      chk("beat3", aq[3], 32'h1004);
      chk("beat0_nonseq", tq[0], 2'b10);
      chk("beat1_seq", tq[1], 2'b11);
    end
    rdc("hit100c", 32'h100C, -1, 32'hDEAD100C, 0);
    rdc("hit1000", 32'h1000, -1, 32'hDEAD1000, 0);
    rdc("miss3000", 32'h3000, -1, 32'hDEAD3000, 6);
    rdc("miss5000", 32'h5000, -1, 32'hDEAD5000, 6);
    rdc("hit3000", 32'h3000, -1, 32'hDEAD3000, 0);
    rdc("evict1000", 32'h1000, -1, 32'hDEAD1000, 6);
    rdc("hit5000", 32'h5000, -1, 32'hDEAD5000, 0);
    earm = 1'b1;
    rd(32'h0040, 1'b0, -1, d, ws, r, rw);
    earm = 1'b0;
    chk("err_waits", ws, 6);
    chk("err1_resp", rw, 1);
    chk("err2_resp", r, 1);
    chk("err_rdata", d, 0);
    rdc("reread0040", 32'h0040, -1, 32'hDEAD0040, 6);
    rdc("stream0044", 32'h0044, -1, 32'hDEAD0044, 0);
    rdc("stream0048", 32'h0048, -1, 32'hDEAD0048, 0);
    rdc("stream004c", 32'h004C, -1, 32'hDEAD004C, 0);
    idle_cycle();
    chk("idle_rdata", bus.s_hrdata, 0);
    bus.inv = 1'b1;
    idle_cycle();
    bus.inv = 1'b0;
    chk("flush_ready", bus.s_hreadyout, 1);
    idle_cycle();
    rdc("postinv0044", 32'h0044, -1, 32'hDEAD0044, 6);
    idle_cycle();
    rdc("invaddr0048", 32'h0048, 0, 32'hDEAD0048, 6);
    rdc("hit004c", 32'h004C, -1, 32'hDEAD004C, 0);
    rdc("pendinv0080", 32'h0080, 3, 32'hDEAD0080, 6);
    rdc("pendmiss0084", 32'h0084, -1, 32'hDEAD0084, 6);
    rdc("hit0088", 32'h0088, -1, 32'hDEAD0088, 0);
    idle_cycle();
    n0 = nact;
    rd(32'h0084, 1'b1, -1, d, ws, r, rw);
    chk("wr_waits", ws, 0);
    chk("wr_resp", r, 0);
    chk("wr_rdata", d, 0);
    idle_cycle();
    chk("wr_noact", nact, n0);
    bus.s_haddr = 32'h0100;
    bus.s_htrans = 2'b10;
    idle_cycle();
    bus.s_htrans = 2'b00;
    idle_cycle();
    idle_cycle();
    chk("refill_seq", bus.m_htrans, 2'b11);
    hrst = 1'b1;
    idle_cycle();
    chk("rst_abort_htrans", bus.m_htrans, 0);
    chk("rst_abort_haddr", bus.m_haddr, 0);
    chk("rst_abort_ready", bus.s_hreadyout, 1);
    hrst = 1'b0;
    rdc("rstmiss0088", 32'h0088, -1, 32'hDEAD0088, 6);
    rdc("rstmiss0100", 32'h0100, -1, 32'hDEAD0100, 6);
    rdc("rstmiss100c", 32'h100C, -1, 32'hDEAD100C, 6);
    idle_cycle();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
